// File: rtl/la_rstseq_pkg.sv
// Shared types and sizing helpers for the la_rstseq reset sequencer.
package la_rstseq_pkg;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to hold a count of 0..delay.
    function automatic int cnt_width(input int delay);
        return $clog2(delay + 1);
    endfunction

    // Bits for the release index; one spare bit keeps N=1 legal.
    function automatic int idx_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/la_rstsync.sv
// Async-assert / sync-deassert reset synchroniser, SYNCSTAGES flops deep.
module la_rstsync #(
    parameter int SYNCSTAGES = 2
) (
    input  logic clk,
    input  logic nreset,
    output logic nrst_sync
);

    logic [SYNCSTAGES-1:0] sync_q;

    // Shift a constant 1 through the chain; nreset clears every stage at once.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNCSTAGES-2:0], 1'b1};
        end
    end

    assign nrst_sync = sync_q[SYNCSTAGES-1];

endmodule

// File: rtl/la_rstseq.sv
// Staged reset sequencer: releases N active-low reset nets one at a time,
// DELAY clk cycles apart, after a synchronised board-reset deassertion.
module la_rstseq
    import la_rstseq_pkg::*;
#(
    parameter int N          = 4,
    parameter int DELAY      = 16,
    parameter int SYNCSTAGES = 2,
    parameter     PROP       = "DEFAULT"
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         sw_nreset,
    input  logic         hold,
    output logic [N-1:0] nrst_out,
    output logic         done
);

    localparam int CW = cnt_width(DELAY);
    localparam int IW = idx_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    // PROP selects implementation variants; only the default exists.
    if (PROP != "DEFAULT") begin : g_prop_custom
    end

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic            soft_wait;
    logic            nrst_sync;
    logic            advance;
    logic [N-1:0]    rel_mask;

    la_rstsync #(
        .SYNCSTAGES(SYNCSTAGES)
    ) u_sync (
        .clk       (clk),
        .nreset    (nreset),
        .nrst_sync (nrst_sync)
    );

    // A counting edge: COUNT without hold, or the edge that first sees the
    // synchroniser high (that edge already counts as the first tick).
    always_comb begin
        advance = 1'b0;
        if (state == COUNT && !hold) begin
            advance = 1'b1;
        end else if (state == RST && !soft_wait && nrst_sync) begin
            advance = 1'b1;
        end
    end

    // One-hot select of the output bit released at terminal count.
    always_comb begin
        rel_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rel_mask[i] = (idx == IW'(i));
        end
    end

    // Sequencer FSM with registered outputs; soft restart waits in RST
    // without touching the synchroniser and re-enters COUNT with counter=0.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= RST;
            cnt       <= '0;
            idx       <= '0;
            soft_wait <= 1'b0;
            nrst_out  <= '0;
            done      <= 1'b0;
        end else if (!sw_nreset) begin
            state     <= RST;
            cnt       <= '0;
            idx       <= '0;
            soft_wait <= 1'b1;
            nrst_out  <= '0;
            done      <= 1'b0;
        end else if (state == RST && soft_wait) begin
            state     <= COUNT;
            cnt       <= '0;
            soft_wait <= 1'b0;
        end else if (advance) begin
            if (cnt == CNT_LAST) begin
                nrst_out <= nrst_out | rel_mask;
                cnt      <= '0;
                if (idx == IDX_LAST) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= COUNT;
                end
            end else begin
                cnt   <= cnt + 1'b1;
                state <= COUNT;
            end
        end
    end

endmodule

// File: tb/tb_la_rstseq.sv
// Scoreboard bench for la_rstseq: stimulus queues edge-stamped expectations,
// a monitor pops and compares them at the negedge after the stamped edge.
module tb_la_rstseq;

    typedef struct {
        int         at;
        logic [3:0] exp_out;
        logic       exp_done;
        bit         sel;
        string      nm;
    } exp_t;

    logic       clk;
    logic       nreset;
    logic       nreset1;
    logic       sw_nreset;
    logic       hold;
    logic [3:0] nrst_out;
    logic       done;
    logic       nrst_out1;
    logic       done1;

    int   edge_n = 0;
    int   total  = 0;
    int   bad    = 0;
    exp_t sb[$];
    event ev_now;

    la_rstseq u_dut (
        .clk       (clk),
        .nreset    (nreset),
        .sw_nreset (sw_nreset),
        .hold      (hold),
        .nrst_out  (nrst_out),
        .done      (done)
    );

    la_rstseq #(
        .N          (1),
        .DELAY      (1),
        .SYNCSTAGES (3)
    ) u_small (
        .clk       (clk),
        .nreset    (nreset1),
        .sw_nreset (1'b1),
        .hold      (1'b0),
        .nrst_out  (nrst_out1),
        .done      (done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: compare every expectation whose edge stamp has been reached.
    always begin
        @(negedge clk or ev_now);
        while (sb.size() > 0 && sb[0].at <= edge_n) begin
            exp_t e;
            logic [3:0] act_out;
            logic       act_done;
            e = sb.pop_front();
            act_out  = e.sel ? {3'b000, nrst_out1} : nrst_out;
            act_done = e.sel ? done1 : done;
            total++;
            if (act_out !== e.exp_out || act_done !== e.exp_done) begin
                bad++;
                $display("FAIL %s @edge %0d: got nrst_out=%b done=%b, want nrst_out=%b done=%b",
                         e.nm, e.at, act_out, act_done, e.exp_out, e.exp_done);
            end
        end
    end

    task automatic push(input int at, input logic [3:0] o, input logic d,
                        input bit sel, input string nm);
        exp_t e;
        e.at = at; e.exp_out = o; e.exp_done = d; e.sel = sel; e.nm = nm;
        sb.push_back(e);
    endtask

    // Expect each bit low on the edge before its release and high on it.
    task automatic push_seq(input int base, input int r0, input int r1,
                            input int r2, input int r3, input string nm);
        int r[4];
        logic [3:0] m;
        r = '{r0, r1, r2, r3};
        m = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            push(base + r[i] - 1, m, 1'b0, 1'b0, nm);
            m[i] = 1'b1;
            push(base + r[i], m, (i == 3), 1'b0, nm);
        end
    endtask

    task automatic drain(input int lim);
        for (int k = 0; k < lim && sb.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    // Board reset low for 5 cycles; returns the edge count at release.
    task automatic do_reset(output int base);
        @(negedge clk);
        nreset    = 1'b0;
        sw_nreset = 1'b1;
        hold      = 1'b0;
        push(edge_n + 1, 4'b0000, 1'b0, 1'b0, "reset_state");
        repeat (5) @(negedge clk);
        nreset = 1'b1;
        base   = edge_n;
    endtask

    initial begin
        int base;
        nreset    = 1'b0;
        nreset1   = 1'b0;
        sw_nreset = 1'b1;
        hold      = 1'b0;
        repeat (2) @(negedge clk);

        // Plain sequence, defaults.
        do_reset(base);
        push_seq(base, 18, 34, 50, 66, "seq");
        push(base + 80, 4'b1111, 1'b1, 1'b0, "done_holds");
        drain(150);

        // Async reset mid-sequence, then a full re-run.
        do_reset(base);
        push(base + 17, 4'b0000, 1'b0, 1'b0, "pre_async");
        push(base + 18, 4'b0001, 1'b0, 1'b0, "pre_async");
        push(base + 34, 4'b0011, 1'b0, 1'b0, "pre_async");
        wait_edge(base + 40);
        #1;
        nreset = 1'b0;
        #1;
        push(edge_n, 4'b0000, 1'b0, 1'b0, "async_clear");
        -> ev_now;
        #1;
        drain(5);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        base   = edge_n;
        push_seq(base, 18, 34, 50, 66, "rerun");
        drain(150);

        // hold sampled high on edges 25..34.
        do_reset(base);
        push_seq(base, 18, 44, 60, 76, "hold");
        wait_edge(base + 24);
        hold = 1'b1;
        wait_edge(base + 34);
        hold = 1'b0;
        drain(150);

        // Soft restart from DONE.
        do_reset(base);
        push_seq(base, 18, 34, 50, 66, "seq2");
        push(base + 70, 4'b1111, 1'b1, 1'b0, "sw_pre");
        push(base + 71, 4'b0000, 1'b0, 1'b0, "sw_clear");
        push(base + 87, 4'b0000, 1'b0, 1'b0, "sw_rerun");
        push(base + 88, 4'b0001, 1'b0, 1'b0, "sw_rerun");
        push(base + 104, 4'b0011, 1'b0, 1'b0, "sw_rerun");
        wait_edge(base + 70);
        sw_nreset = 1'b0;
        @(negedge clk);
        sw_nreset = 1'b1;
        drain(150);

        // Soft restart together with hold during COUNT.
        do_reset(base);
        push(base + 18, 4'b0001, 1'b0, 1'b0, "swhold_pre");
        push(base + 29, 4'b0001, 1'b0, 1'b0, "swhold_pre");
        push(base + 30, 4'b0000, 1'b0, 1'b0, "swhold_clear");
        push(base + 46, 4'b0000, 1'b0, 1'b0, "swhold_rerun");
        push(base + 47, 4'b0001, 1'b0, 1'b0, "swhold_rerun");
        push(base + 63, 4'b0011, 1'b0, 1'b0, "swhold_rerun");
        wait_edge(base + 29);
        sw_nreset = 1'b0;
        hold      = 1'b1;
        @(negedge clk);
        sw_nreset = 1'b1;
        @(negedge clk);
        hold = 1'b0;
        drain(150);

        // N=1, DELAY=1, SYNCSTAGES=3 instance.
        @(negedge clk);
        nreset1 = 1'b0;
        push(edge_n + 1, 4'b0000, 1'b0, 1'b1, "small_reset");
        repeat (3) @(negedge clk);
        nreset1 = 1'b1;
        base    = edge_n;
        push(base + 3, 4'b0000, 1'b0, 1'b1, "small_pre");
        push(base + 4, 4'b0001, 1'b1, 1'b1, "small_rel");
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
